// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller for a simple dual-port RAM (port A writes, port B reads).
// A 2-entry output buffer absorbs the 1-cycle RAM read latency for bubble-free streaming.
module dpram_fifo_ctrl #(
    parameter int unsigned DW    = 64,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_dob,
    output logic [AW:0]   ram_level
);
    localparam int unsigned   CW        = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] ram_cnt_q, ram_cnt_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic [DW-1:0] ob0_q, ob0_d;
    logic [DW-1:0] ob1_q, ob1_d;

    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] ob_claim;

    // Handshakes and read issue; a read is only issued if its data is sure to find a buffer slot
    always_comb begin
        s_ready  = rstn & ~flush & (ram_cnt_q < FULL_CNT);
        push     = s_valid & s_ready;
        m_valid  = (ob_cnt_q != 2'd0) & ~flush;
        pop      = m_valid & m_ready;
        ob_claim = 3'(ob_cnt_q) + 3'(rd_inflight_q) - 3'(pop);
        issue    = rstn & ~flush & (ram_cnt_q != '0) & (ob_claim < 3'd2);
    end

    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wptr_q;
    assign ram_dia   = s_data;
    assign ram_enb   = issue;
    assign ram_addrb = rptr_q;
    assign ram_level = ram_cnt_q;
    assign m_data    = ob0_q;

    // Next-state: pointers, occupancy and the in-order output buffer
    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        ram_cnt_d     = ram_cnt_q + CW'(push) - CW'(issue);
        rd_inflight_d = issue;
        ob0_d         = ob0_q;
        ob1_d         = ob1_q;
        ob_cnt_d      = ob_cnt_q - 2'(pop) + 2'(rd_inflight_q);

        if (push) begin
            wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + AW'(1);
        end
        if (issue) begin
            rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + AW'(1);
        end
        if (pop) begin
            ob0_d = ob1_q;
        end
        // Returning word lands at the tail as seen after this cycle's pop
        if (rd_inflight_q) begin
            if ((ob_cnt_q - 2'(pop)) == 2'd0) begin
                ob0_d = ram_dob;
            end else begin
                ob1_d = ram_dob;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            ob_cnt_q      <= 2'd0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            ob_cnt_q      <= ob_cnt_d;
        end
    end

    // Buffer payload needs no reset; validity is tracked by ob_cnt_q
    always_ff @(posedge clk) begin
        ob0_q <= ob0_d;
        ob1_q <= ob1_d;
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed and random bench for dpram_fifo_ctrl: a DEPTH=4 instance for fill/full/flush/soak
// and a DEPTH=208 instance for pointer wrap and streaming.
`timescale 1ns/1ps
module tb_dpram_fifo_ctrl;
    localparam int unsigned DW      = 16;
    localparam int unsigned AW_A    = 2;
    localparam int unsigned DEPTH_A = 4;
    localparam int unsigned AW_B    = 8;
    localparam int unsigned DEPTH_B = 208;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic            a_flush = 1'b0, a_s_valid = 1'b0, a_m_ready = 1'b0;
    logic [DW-1:0]   a_s_data = '0;
    logic            a_s_ready, a_m_valid, a_ram_ena, a_ram_wea, a_ram_enb;
    logic [DW-1:0]   a_m_data, a_ram_dia, a_ram_dob;
    logic [AW_A-1:0] a_ram_addra, a_ram_addrb;
    logic [AW_A:0]   a_ram_level;

    logic            b_flush = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b0;
    logic [DW-1:0]   b_s_data = '0;
    logic            b_s_ready, b_m_valid, b_ram_ena, b_ram_wea, b_ram_enb;
    logic [DW-1:0]   b_m_data, b_ram_dia, b_ram_dob;
    logic [AW_B-1:0] b_ram_addra, b_ram_addrb;
    logic [AW_B:0]   b_ram_level;

    dpram_fifo_ctrl #(.DW(DW), .AW(AW_A), .DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rstn(rstn), .flush(a_flush),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .ram_ena(a_ram_ena), .ram_wea(a_ram_wea), .ram_addra(a_ram_addra), .ram_dia(a_ram_dia),
        .ram_enb(a_ram_enb), .ram_addrb(a_ram_addrb), .ram_dob(a_ram_dob), .ram_level(a_ram_level)
    );

    dpram_fifo_ctrl #(.DW(DW), .AW(AW_B), .DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rstn(rstn), .flush(b_flush),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .ram_ena(b_ram_ena), .ram_wea(b_ram_wea), .ram_addra(b_ram_addra), .ram_dia(b_ram_dia),
        .ram_enb(b_ram_enb), .ram_addrb(b_ram_addrb), .ram_dob(b_ram_dob), .ram_level(b_ram_level)
    );

    // Behavioural simple dual-port RAMs with 1-cycle registered read
    logic [DW-1:0] mem_a [DEPTH_A];
    logic [DW-1:0] mem_b [256];
    always @(posedge clk) begin
        if (a_ram_ena && a_ram_wea) mem_a[a_ram_addra] <= a_ram_dia;
        if (a_ram_enb) a_ram_dob <= mem_a[a_ram_addrb];
        if (b_ram_ena && b_ram_wea) mem_b[b_ram_addra] <= b_ram_dia;
        if (b_ram_enb) b_ram_dob <= mem_b[b_ram_addrb];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    // Scoreboard for instance A: write order in, same order out, buffer never over-committed
    logic [DW-1:0] sb_q [$];
    always @(negedge clk) begin
        if (!rstn || a_flush) begin
            sb_q.delete();
        end else begin
            if (a_m_valid && a_m_ready) begin
                check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) check_eq("sb_order", 64'(a_m_data), 64'(sb_q.pop_front()));
            end
            if (a_s_valid && a_s_ready) sb_q.push_back(a_s_data);
            check_eq("inv_ob_slots",
                     64'((int'(dut_a.ob_cnt_q) + int'(dut_a.rd_inflight_q)) <= 2), 64'd1);
        end
    end

    logic [9:0]    acc_mask;
    logic [AW_A:0] max_lvl;
    logic [DW-1:0] wd;
    logic          pushed, seen;
    int            n_out, n_push, n_pop, n_sent, n_recv, n_iss;

    initial begin
        // Reset
        repeat (3) step_edge();
        to_mid();
        check_eq("rst_s_ready_low", 64'(a_s_ready), 64'd0);
        check_eq("rst_enb_low", 64'(a_ram_enb), 64'd0);
        step_edge();
        rstn = 1'b1;
        to_mid();
        check_eq("rst_s_ready", 64'(a_s_ready), 64'd1);
        check_eq("rst_m_valid", 64'(a_m_valid), 64'd0);
        check_eq("rst_ena", 64'({a_ram_ena, a_ram_wea}), 64'd0);
        check_eq("rst_enb", 64'(a_ram_enb), 64'd0);
        check_eq("rst_addra", 64'(a_ram_addra), 64'd0);
        check_eq("rst_addrb", 64'(a_ram_addrb), 64'd0);
        check_eq("rst_level", 64'(a_ram_level), 64'd0);
        check_eq("rst_b_s_ready", 64'(b_s_ready), 64'd1);
        step_edge();

        // Single word: 3-cycle latency into an empty FIFO
        a_s_valid = 1'b1; a_s_data = 16'h00A5; a_m_ready = 1'b1;
        to_mid();
        check_eq("t1_s_ready", 64'(a_s_ready), 64'd1);
        check_eq("t1_ena", 64'(a_ram_ena), 64'd1);
        step_edge();
        a_s_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            to_mid();
            check_eq($sformatf("t1_m_valid_c%0d", c), 64'(a_m_valid), 64'(c == 3));
            if (c == 3) check_eq("t1_m_data", 64'(a_m_data), 64'h00A5);
            check_eq($sformatf("t1_enb_c%0d", c), 64'(a_ram_enb), 64'(c == 1));
            check_eq($sformatf("t1_level_c%0d", c), 64'(a_ram_level), 64'(c == 1));
            step_edge();
        end

        // Fill with consumer stalled: DEPTH + 2 words accepted
        a_m_ready = 1'b0;
        acc_mask  = '0;
        for (int i = 0; i < 10; i++) begin
            a_s_valid = 1'b1; a_s_data = 16'(i);
            to_mid();
            if (a_s_ready) acc_mask[i] = 1'b1;
            step_edge();
        end
        a_s_valid = 1'b0;
        to_mid();
        check_eq("t2_accept_mask", 64'(acc_mask), 64'h3F);
        check_eq("t2_s_ready", 64'(a_s_ready), 64'd0);
        check_eq("t2_level", 64'(a_ram_level), 64'd4);
        check_eq("t2_m_valid", 64'(a_m_valid), 64'd1);
        step_edge();
        a_m_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 12; c++) begin
            to_mid();
            if (a_m_valid) begin
                check_eq($sformatf("t2_out%0d", n_out), 64'(a_m_data), 64'(n_out));
                n_out++;
            end
            step_edge();
        end
        check_eq("t2_out_count", 64'(n_out), 64'd6);

        // Push and pop at full
        a_m_ready = 1'b0; a_s_valid = 1'b1; wd = 16'h0100; a_s_data = wd; n_push = 0;
        for (int c = 0; c < 20; c++) begin
            to_mid();
            if (!a_s_ready) break;
            n_push++;
            step_edge();
            wd++; a_s_data = wd;
        end
        check_eq("t3_fill_count", 64'(n_push), 64'd6);
        check_eq("t3_fill_level", 64'(a_ram_level), 64'd4);
        step_edge();
        a_m_ready = 1'b1; n_pop = 0; max_lvl = '0;
        for (int c = 0; c < 30; c++) begin
            to_mid();
            if (c == 0) begin
                check_eq("t3_first_issue", 64'(a_ram_enb), 64'd1);
                check_eq("t3_full_no_accept", 64'(a_s_ready), 64'd0);
            end
            if (c == 1) check_eq("t3_accept_resumes", 64'(a_s_ready), 64'd1);
            pushed = a_s_valid && a_s_ready;
            if (pushed) n_push++;
            if (a_m_valid) n_pop++;
            if (a_ram_level > max_lvl) max_lvl = a_ram_level;
            step_edge();
            if (pushed) begin wd++; a_s_data = wd; end
        end
        a_s_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            to_mid();
            if (a_m_valid) n_pop++;
            step_edge();
        end
        check_eq("t3_max_level", 64'(max_lvl), 64'd4);
        check_eq("t3_push_count", 64'(n_push), 64'd35);
        check_eq("t3_pop_count", 64'(n_pop), 64'd35);
        check_eq("t3_sb_drained", 64'(sb_q.size()), 64'd0);

        // Flush while a read is returning and another is about to issue
        a_m_ready = 1'b0; a_s_valid = 1'b1; a_s_data = 16'h0077;
        to_mid();
        step_edge();
        a_s_data = 16'h0078;
        to_mid();
        check_eq("t4_enb_before", 64'(a_ram_enb), 64'd1);
        step_edge();
        a_s_valid = 1'b0; a_flush = 1'b1;
        to_mid();
        check_eq("t4_flush_enb", 64'(a_ram_enb), 64'd0);
        check_eq("t4_flush_s_ready", 64'(a_s_ready), 64'd0);
        check_eq("t4_flush_m_valid", 64'(a_m_valid), 64'd0);
        step_edge();
        a_flush = 1'b0; a_s_valid = 1'b1; a_s_data = 16'h003C; a_m_ready = 1'b1;
        to_mid();
        check_eq("t4_post_m_valid", 64'(a_m_valid), 64'd0);
        check_eq("t4_post_level", 64'(a_ram_level), 64'd0);
        check_eq("t4_post_addra", 64'(a_ram_addra), 64'd0);
        check_eq("t4_post_addrb", 64'(a_ram_addrb), 64'd0);
        step_edge();
        a_s_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            to_mid();
            check_eq($sformatf("t4_m_valid_k%0d", k), 64'(a_m_valid), 64'(k == 3));
            if (k == 3) check_eq("t4_m_data", 64'(a_m_data), 64'h003C);
            step_edge();
        end

        // Wrap on the non-power-of-two instance, both sides always ready
        b_m_ready = 1'b1; n_sent = 0; n_recv = 0; n_iss = 0; seen = 1'b0;
        for (int c = 0; c < 700 && n_recv < 500; c++) begin
            b_s_valid = (n_sent < 500);
            b_s_data  = 16'(n_sent);
            to_mid();
            if (b_s_valid && b_s_ready) begin
                check_eq("t5_addra", 64'(b_ram_addra), 64'(n_sent % 208));
                n_sent++;
            end
            if (b_ram_enb) begin
                check_eq("t5_addrb", 64'(b_ram_addrb), 64'(n_iss % 208));
                n_iss++;
            end
            if (seen) check_eq("t5_no_bubble", 64'(b_m_valid), 64'd1);
            if (b_m_valid) begin
                seen = 1'b1;
                check_eq("t5_data", 64'(b_m_data), 64'(n_recv));
                n_recv++;
            end
            step_edge();
        end
        b_s_valid = 1'b0;
        check_eq("t5_recv_count", 64'(n_recv), 64'd500);
        check_eq("t5_issue_count", 64'(n_iss), 64'd500);

        // Random soak, alternating phases that favour filling and draining
        for (int c = 0; c < 10000; c++) begin
            a_s_valid = ($urandom_range(0, 3) < (((c / 500) % 2 == 0) ? 3 : 1));
            a_m_ready = ($urandom_range(0, 3) < (((c / 500) % 2 == 0) ? 1 : 3));
            a_s_data  = 16'($urandom);
            to_mid();
            step_edge();
        end
        a_s_valid = 1'b0; a_m_ready = 1'b1;
        repeat (12) begin
            to_mid();
            step_edge();
        end
        to_mid();
        check_eq("t6_m_valid_idle", 64'(a_m_valid), 64'd0);
        check_eq("t6_level_idle", 64'(a_ram_level), 64'd0);
        check_eq("t6_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller that sequences one `dpram_wrapper` instance: port A is used for writes and port B for reads. The block turns the simple dual-port RAM into a valid/ready stream buffer for feature-map and weight staging between accelerator pipeline stages. It hides the RAM's 1-cycle read latency behind a 2-entry output buffer, so a stream of one word per cycle passes through without bubbles.

## Interface
- `DW`, default 64: data width; must match the wrapped RAM.
- `AW`, default 8: RAM address width.
- `DEPTH`, default 256: RAM words; 2 ≤ DEPTH ≤ 2^AW; need not be a power of two (e.g. 208, 26).

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rstn`  in  1  synchronous active-low reset.
- `flush`  in  1  synchronous clear of all FIFO contents.
- `s_valid`  in  1  write request.
- `s_ready`  out  1  write accept.
- `s_data`  in  DW  write data.
- `m_valid`  out  1  read data available.
- `m_ready`  in  1  consumer accept.
- `m_data`  out  DW  read data.
- `ram_ena`, `ram_wea`  out  1  RAM port A enable and write enable; the two are driven identically.
- `ram_addra`  out  AW  write address (the write pointer).
- `ram_dia`  out  DW  write data; equals `s_data`.
- `ram_enb`  out  1  RAM port B read enable.
- `ram_addrb`  out  AW  read address (the read pointer).
- `ram_dob`  in  DW  RAM read data, valid 1 cycle after `ram_enb`.
- `ram_level`  out  AW+1  number of words currently held in RAM and not yet read.

## Operation
- **State:**
  - `wptr` and `rptr`, each AW bits, wrap from DEPTH-1 to 0.
  - `ram_cnt`, AW+1 bits.
  - `rd_inflight`, 1 bit.
  - Output buffer `ob`: 2 entries, in order, with `ob_cnt` of 0..2.
- **Write:**
  - `s_ready = rstn & ~flush & (ram_cnt < DEPTH)`.
  - `push = s_valid & s_ready`.
  - `ram_ena = ram_wea = push`; `ram_addra = wptr`.
  - `wptr` advances on `push`.
- **Pop:**
  - `m_valid = (ob_cnt != 0) & ~flush`.
  - `m_data` = oldest `ob` entry.
  - `pop = m_valid & m_ready`.
- **Read issue:**
  - `ram_enb = rstn & ~flush & (ram_cnt != 0) & (ob_cnt + rd_inflight - pop < 2)`.
  - `ram_addrb = rptr`; `rptr` advances on issue.
  - The path from `m_ready` to `ram_enb` is combinational by design.
- **Occupancy and return data:**
  - `ram_cnt` increments on push and decrements on issue; when both happen it holds.
  - `rd_inflight` is set on the cycle after an issue.
  - While `rd_inflight` is 1, `ram_dob` is written into `ob` at the tail, in the same cycle as any pop.
- **No address collision:** a read only targets words whose write edge has already passed, so the read and write addresses never collide.
- **Capacity:** DEPTH + 2 words in total (RAM plus output buffer).
- **Ordering:** data leaves in exact write order across pointer wrap.
- **Flush:**
  - Takes effect on the edge where it is sampled high.
  - Clears pointers, `ram_cnt`, `ob_cnt` and `rd_inflight`.
  - A read in flight at that edge returns its data the next cycle; that data is discarded.
  - RAM contents are not cleared.
- **Reset:** identical to flush.
  - Values after reset: `s_ready`=1 (once `rstn` is high), `m_valid`=0, `ram_ena`=`ram_wea`=`ram_enb`=0, `ram_addra`=`ram_addrb`=0, `ram_level`=0, `m_data` undefined.
  - `s_ready` and `ram_enb` are held at 0 while `rstn` is low.

## Timing
- **Write-to-read latency:** for a push accepted at the edge ending cycle 0:
  - `ram_enb` = 1 in cycle 1.
  - `ram_dob` is valid in cycle 2.
  - `m_valid` = 1 in cycle 3.
  - Latency is 3 cycles into an empty FIFO.
- **Throughput:** sustained 1 word/cycle in and out once primed, with `s_valid` and `m_ready` continuously high.
- **Full-side backpressure:** `s_ready` depends on `ram_cnt` only, not on a same-cycle read issue. When the RAM is full, a read frees a slot that becomes visible the following cycle, so one accept is lost.
- **Consumer stall:** the output buffer never overflows. The issue rule guarantees that in-flight data always has a slot.
- **Simultaneous push and issue at `ram_cnt`=DEPTH:** cannot happen, because `s_ready`=0.
- **Simultaneous push and issue at `ram_cnt`=0:** cannot happen, because `ram_enb`=0.

## Test plan
- **Single word:** reset, then push 0xA5 in cycle 0 with `m_ready`=1. `m_valid`=1 and `m_data`=0xA5 in cycle 3 only; `ram_level` goes back to 0 by cycle 2.
- **Fill with consumer stalled (DEPTH=4):** push 0..9 with `m_ready`=0.
  - Exactly 6 words are accepted; `s_ready` drops after the 6th; `ram_level`=4.
  - Then release `m_ready` and check the output is 0..5 in order.
- **Wrap with non-power-of-two depth (DEPTH=208):** stream 500 words with both sides always ready.
  - `ram_addra` and `ram_addrb` each run 0..207 and then wrap to 0.
  - Output is in order with no bubbles after the first `m_valid`.
- **Push and pop at full (DEPTH=4):** fill the FIFO, then hold `s_valid`=`m_ready`=1.
  - Accepts resume one cycle after the first issue.
  - No data is lost or duplicated, and `ram_level` never exceeds 4.
- **Flush with a read in flight:** assert `flush` in a cycle where `ram_enb`=1.
  - `m_valid`=0 on the next cycle and `ram_level`=0.
  - The returning word never appears.
  - A new push of 0x3C comes out 3 cycles later.
- **Random soak:** 10k cycles with random `s_valid`/`m_ready`, with a scoreboard checking order and count and the invariant `ob_cnt + rd_inflight ≤ 2`.
